// File: rtl/sme_match_serializer.sv
// Match-word buffer and serialiser: queues non-zero match words and presents one index per pop.
// Optional MATCH_DEDUP_EN masks duplicate slots (within a word and against the last popped index).
module sme_match_serializer #(
  parameter int NUM_SLOTS       = 8,
  parameter int INDEX_WIDTH     = 16,
  parameter int FIFO_ADDR_WIDTH = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_SLOTS*INDEX_WIDTH-1:0] in_data,
  input  logic                           in_valid,
  input  logic                           reload,
  input  logic                           next_index,
  output logic [INDEX_WIDTH-1:0]         match_index,
  output logic                           match_valid,
  output logic [NUM_SLOTS-1:0]           match_valid_stat,
  output logic                           overflow,
  output logic [CNT_WIDTH-1:0]           drop_count,
  output logic                           busy
);

  localparam int DEPTH = 1 << FIFO_ADDR_WIDTH;
  localparam int WORD_W = NUM_SLOTS * INDEX_WIDTH;

  logic [WORD_W-1:0]          mem [DEPTH];
  logic [FIFO_ADDR_WIDTH:0]   wr_ptr, rd_ptr;
  logic [WORD_W-1:0]          hold_data;
  logic [NUM_SLOTS-1:0]       pending;
  logic [NUM_SLOTS-1:0]       load_mask;
  logic [WORD_W-1:0]          head;
  logic [INDEX_WIDTH-1:0]     low_idx;
  logic                       fifo_empty, fifo_full;
  logic                       wr_req, wr_en, drop, rd_en, pop;
`ifdef MATCH_DEDUP_EN
  logic [INDEX_WIDTH-1:0]     last_idx;
`endif

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[FIFO_ADDR_WIDTH] != rd_ptr[FIFO_ADDR_WIDTH]) &&
                      (wr_ptr[FIFO_ADDR_WIDTH-1:0] == rd_ptr[FIFO_ADDR_WIDTH-1:0]);
  assign wr_req = in_valid && (|in_data);
  assign wr_en  = wr_req && !fifo_full;
  assign drop   = wr_req && fifo_full;
  assign rd_en  = (pending == '0) && !fifo_empty;
  assign pop    = next_index && match_valid;
  assign head   = mem[rd_ptr[FIFO_ADDR_WIDTH-1:0]];
  assign busy   = !fifo_empty || (|pending);

  always_comb begin
    load_mask = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      load_mask[k] = (head[k*INDEX_WIDTH +: INDEX_WIDTH] != '0);
`ifdef MATCH_DEDUP_EN
      if (head[k*INDEX_WIDTH +: INDEX_WIDTH] == last_idx) load_mask[k] = 1'b0;
      for (int j = 0; j < k; j++) begin
        if (head[j*INDEX_WIDTH +: INDEX_WIDTH] == head[k*INDEX_WIDTH +: INDEX_WIDTH])
          load_mask[k] = 1'b0;
      end
`endif
    end
  end

  // Lowest pending slot wins; zero when nothing is pending.
  always_comb begin
    low_idx = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (pending[k]) low_idx = hold_data[k*INDEX_WIDTH +: INDEX_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !(rst || reload)) mem[wr_ptr[FIFO_ADDR_WIDTH-1:0]] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst || reload) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      hold_data        <= '0;
      pending          <= '0;
      match_valid      <= 1'b0;
      match_index      <= '0;
      match_valid_stat <= '0;
      overflow         <= 1'b0;
      drop_count       <= '0;
`ifdef MATCH_DEDUP_EN
      last_idx         <= '0;
`endif
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
      // A fully masked word still leaves the FIFO; pending stays zero so the next word loads next cycle.
      if (rd_en) begin
        rd_ptr    <= rd_ptr + 1'b1;
        hold_data <= head;
        pending   <= load_mask;
      end else if (pop) begin
        pending <= pending & (pending - NUM_SLOTS'(1));
      end
`ifdef MATCH_DEDUP_EN
      if (pop) last_idx <= match_index;
`endif
      match_valid      <= (|pending) && !pop;
      match_index      <= low_idx;
      match_valid_stat <= pending;
    end
  end

endmodule

// File: tb/tb_sme_match_serializer.sv
// Directed bench for sme_match_serializer: vector table plus multi-cycle sequences.
// Build with or without MATCH_DEDUP_EN; the duplicate-word sequence adapts to either.
module tb_sme_match_serializer;
  localparam int NS = 8;
  localparam int IW = 16;

  logic            clk = 1'b0;
  logic            rst, in_valid, reload, next_index;
  logic [NS*IW-1:0] in_data;
  logic [IW-1:0]   match_index;
  logic            match_valid, overflow, busy;
  logic [NS-1:0]   match_valid_stat;
  logic [15:0]     drop_count;

  int checks = 0;
  int errors = 0;

  sme_match_serializer dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .reload(reload),
    .next_index(next_index), .match_index(match_index), .match_valid(match_valid),
    .match_valid_stat(match_valid_stat), .overflow(overflow), .drop_count(drop_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            iv;
    logic [NS*IW-1:0] data;
    logic            nx;
    logic            e_valid;
    logic [IW-1:0]   e_index;
    logic [NS-1:0]   e_stat;
    logic            e_busy;
  } vec_t;

  function automatic logic [NS*IW-1:0] sl(input int k, input logic [IW-1:0] v);
    logic [NS*IW-1:0] w;
    w = '0;
    w[k*IW +: IW] = v;
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    in_valid = 1'b0; in_data = '0; next_index = 1'b0; reload = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!match_valid && n < 12) begin step(); n++; end
    if (!match_valid) begin
      checks++; errors++;
      $display("FAIL %s: match_valid timeout got 0 expected 1", name);
    end
  endtask

  task automatic pop_one;
    next_index = 1'b1; step(); next_index = 1'b0;
  endtask

  vec_t vt [18];
  logic [NS*IW-1:0] w1, w2;
  logic [IW-1:0] exp_q [$];

  initial begin
    w1 = sl(0, 16'd5) | sl(3, 16'd9) | sl(7, 16'd2);
    w2 = sl(1, 16'h11) | sl(4, 16'h44);
    //         iv  data  nx  valid idx    stat   busy
    vt[0]  = '{1, w1, 0, 0, 16'd0, 8'h00, 1};
    vt[1]  = '{0, '0, 0, 0, 16'd0, 8'h00, 1};
    vt[2]  = '{0, '0, 0, 1, 16'd5, 8'h89, 1};
    vt[3]  = '{0, '0, 1, 0, 16'd5, 8'h89, 1};
    vt[4]  = '{0, '0, 0, 1, 16'd9, 8'h88, 1};
    vt[5]  = '{0, '0, 1, 0, 16'd9, 8'h88, 1};
    vt[6]  = '{0, '0, 0, 1, 16'd2, 8'h80, 1};
    vt[7]  = '{0, '0, 1, 0, 16'd2, 8'h80, 0};
    vt[8]  = '{0, '0, 0, 0, 16'd0, 8'h00, 0};
    vt[9]  = '{1, '0, 0, 0, 16'd0, 8'h00, 0};
    vt[10] = '{0, '0, 0, 0, 16'd0, 8'h00, 0};
    vt[11] = '{1, w2, 0, 0, 16'd0, 8'h00, 1};
    vt[12] = '{0, '0, 0, 0, 16'd0, 8'h00, 1};
    vt[13] = '{0, '0, 1, 1, 16'h11, 8'h12, 1};
    vt[14] = '{0, '0, 1, 0, 16'h11, 8'h12, 1};
    vt[15] = '{0, '0, 1, 1, 16'h44, 8'h10, 1};
    vt[16] = '{0, '0, 1, 0, 16'h44, 8'h10, 0};
    vt[17] = '{0, '0, 0, 0, 16'd0, 8'h00, 0};

    // Reset with a valid word present: the word must be discarded.
    idle(); rst = 1'b1; in_valid = 1'b1; in_data = w1;
    step(); step();
    rst = 1'b0; idle();
    step();
    chk("rst_valid", match_valid, 0);
    chk("rst_index", match_index, 0);
    chk("rst_stat", match_valid_stat, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_count, 0);

    for (int i = 0; i < 18; i++) begin
      in_valid = vt[i].iv; in_data = vt[i].data; next_index = vt[i].nx;
      step();
      chk($sformatf("v%0d_valid", i), match_valid, vt[i].e_valid);
      chk($sformatf("v%0d_index", i), match_index, vt[i].e_index);
      chk($sformatf("v%0d_stat", i), match_valid_stat, vt[i].e_stat);
      chk($sformatf("v%0d_busy", i), busy, vt[i].e_busy);
    end
    idle();
    chk("zero_word_drop", drop_count, 0);
    chk("zero_word_ovf", overflow, 0);

    // Fill: 1 word in hold + 4 in FIFO, then two dropped words.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = sl(0, 16'(i + 1)); step();
    end
    chk("fill_ovf", overflow, 0);
    chk("fill_drop", drop_count, 0);
    chk("fill_valid", match_valid, 1);
    chk("fill_index", match_index, 1);
    in_data = sl(0, 16'd6); step();
    chk("ovf6", overflow, 1);
    chk("drop6", drop_count, 1);
    in_data = sl(0, 16'd7); step();
    chk("drop7", drop_count, 2);
    idle();
    pop_one();
    // FIFO full at this edge while hold pulls a word out: the write must still be refused.
    in_valid = 1'b1; in_data = sl(0, 16'd8); step(); idle();
    chk("drop_rw", drop_count, 3);
    for (int v = 2; v <= 5; v++) begin
      wait_valid("drain");
      chk($sformatf("drain_%0d", v), match_index, 16'(v));
      pop_one();
    end
    step(); step(); step();
    chk("drain_busy", busy, 0);
    chk("drain_ovf", overflow, 1);
    reload = 1'b1; step(); reload = 1'b0;
    chk("reload_ovf", overflow, 0);
    chk("reload_drop", drop_count, 0);
    chk("reload_valid", match_valid, 0);

    // Reload mid-serialisation with three pending matches.
    in_valid = 1'b1; in_data = w1; step(); idle();
    wait_valid("mid");
    chk("mid_stat", match_valid_stat, 8'h89);
    reload = 1'b1; step(); reload = 1'b0;
    chk("mid_valid", match_valid, 0);
    chk("mid_busy", busy, 0);
    chk("mid_stat0", match_valid_stat, 0);
    step(); step(); step();
    chk("mid_still_idle", match_valid, 0);

    // Duplicate handling.
    in_valid = 1'b1; in_data = sl(0, 16'd7) | sl(1, 16'd7) | sl(2, 16'd4); step();
    in_data = sl(0, 16'd4); step(); idle();
`ifdef MATCH_DEDUP_EN
    exp_q = '{16'd7, 16'd4};
`else
    exp_q = '{16'd7, 16'd7, 16'd4, 16'd4};
`endif
    foreach (exp_q[i]) begin
      wait_valid("dup");
      chk($sformatf("dup_%0d", i), match_index, exp_q[i]);
      pop_one();
    end
    step(); step(); step(); step();
    chk("dup_end_valid", match_valid, 0);
    chk("dup_end_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
